// File: rtl/fp32_pkg.sv
// Shared single-precision constants and types for the fp32 add/sub datapath.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Everything the packing stage needs from the rounding stage.
    typedef struct packed {
        logic [MAN_W-1:0] frac;
        logic             carry;
        logic [EXP_W:0]   exp;
        logic             sign;
        logic             nan;
        logic             inf;
        logic             inf_sign;
        logic             zero;
        logic             neg_e;
        logic             lost;
    } s1_data_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even increment of a 23-bit fraction with guard/round/sticky.
module fp32_round_rne
    import fp32_pkg::*;
(
    input  logic [MAN_W-1:0] norm_m,
    input  logic             fg,
    input  logic             r,
    input  logic             s,
    output logic [MAN_W:0]   rnd,
    output logic             lost
);

    logic round_up_s;

    // A tie (fg set, r and s clear) only rounds up when the fraction is odd.
    always_comb begin
        round_up_s = fg & (r | s | norm_m[0]);
        rnd        = {1'b0, norm_m} + {{MAN_W{1'b0}}, round_up_s};
        lost       = fg | r | s;
    end

endmodule

// File: rtl/fp_addsub_round_32.sv
// Final round-and-pack stage of the fp32 add/sub datapath: two-stage elastic pipeline.
module fp_addsub_round_32
    import fp32_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] norm_m,
    input  logic [EXP_W:0]   norm_e,
    input  logic             fg,
    input  logic             r,
    input  logic             s,
    input  logic             zero_sum,
    input  logic             neg_e,
    input  logic             sign,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             inf_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow,
    output logic             underflow,
    output logic             inexact
);

    logic [MAN_W:0]   rnd_s;
    logic             lost_s;
    logic             s2_take_s;
    logic             s1_take_s;
    logic [EXP_W+1:0] e_fin_s;
    logic [31:0]      pack_res_s;
    fp_flags_t        pack_flg_s;

    logic             s1_valid_d, s1_valid_q;
    s1_data_t         s1_d, s1_q;
    logic             out_valid_d, out_valid_q;
    logic [31:0]      result_d, result_q;
    fp_flags_t        flags_d, flags_q;

    fp32_round_rne u_round (
        .norm_m (norm_m),
        .fg     (fg),
        .r      (r),
        .s      (s),
        .rnd    (rnd_s),
        .lost   (lost_s)
    );

    // Handshake: a stage may load when empty or when its content moves on.
    always_comb begin
        s2_take_s = ~out_valid_q | out_ready;
        s1_take_s = ~s1_valid_q | s2_take_s;
        in_ready  = s1_take_s;
    end

    // Stage 1 capture of the rounded fraction and pass-through fields.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_take_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.frac     = rnd_s[MAN_W-1:0];
                s1_d.carry    = rnd_s[MAN_W];
                s1_d.exp      = norm_e;
                s1_d.sign     = sign;
                s1_d.nan      = in_nan;
                s1_d.inf      = in_inf;
                s1_d.inf_sign = inf_sign;
                s1_d.zero     = zero_sum;
                s1_d.neg_e    = neg_e;
                s1_d.lost     = lost_s;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 classification; a mantissa carry leaves a zero fraction, so frac is used as-is.
    always_comb begin
        e_fin_s    = {1'b0, s1_q.exp} + {{(EXP_W+1){1'b0}}, s1_q.carry};
        pack_res_s = {s1_q.sign, e_fin_s[EXP_W-1:0], s1_q.frac};
        pack_flg_s = '{overflow: 1'b0, underflow: 1'b0, inexact: s1_q.lost};
        if (s1_q.nan) begin
            pack_res_s = QNAN;
            pack_flg_s = '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
        end else if (s1_q.inf) begin
            pack_res_s = {s1_q.inf_sign, EXP_MAX, {MAN_W{1'b0}}};
            pack_flg_s = '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
        end else if (s1_q.zero) begin
            pack_res_s = 32'h00000000;
            pack_flg_s = '{overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
        end else if (s1_q.neg_e || (e_fin_s == 10'd0)) begin
            pack_res_s = {s1_q.sign, 31'h00000000};
            pack_flg_s = '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
        end else if (e_fin_s >= 10'd255) begin
            pack_res_s = {s1_q.sign, EXP_MAX, {MAN_W{1'b0}}};
            pack_flg_s = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
        end else begin
            pack_res_s = {s1_q.sign, e_fin_s[EXP_W-1:0], s1_q.frac};
            pack_flg_s = '{overflow: 1'b0, underflow: 1'b0, inexact: s1_q.lost};
        end
    end

    // Output register next state; holds while stalled by the consumer.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (s2_take_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = pack_res_s;
                flags_d  = pack_flg_s;
            end else begin
                result_d = result_q;
                flags_d  = flags_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 32'h00000000;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = flags_q.overflow;
    assign underflow = flags_q.underflow;
    assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_addsub_round_32.sv
// Directed-vector bench for fp_addsub_round_32: rounding, specials, backpressure, reset.
module tb_fp_addsub_round_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] norm_m;
    logic [8:0]  norm_e;
    logic        fg, r, s;
    logic        zero_sum, neg_e, sign;
    logic        in_nan, in_inf, inf_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow, underflow, inexact;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [22:0] m;
        logic [8:0]  e;
        logic        fg, r, s, zero, neg, sgn, nan, inf, inf_sgn;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[15];

    fp_addsub_round_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .norm_m    (norm_m),
        .norm_e    (norm_e),
        .fg        (fg),
        .r         (r),
        .s         (s),
        .zero_sum  (zero_sum),
        .neg_e     (neg_e),
        .sign      (sign),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .inf_sign  (inf_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        norm_m   = v.m;
        norm_e   = v.e;
        fg       = v.fg;
        r        = v.r;
        s        = v.s;
        zero_sum = v.zero;
        neg_e    = v.neg;
        sign     = v.sgn;
        in_nan   = v.nan;
        in_inf   = v.inf;
        inf_sign = v.inf_sgn;
    endtask

    // Send one vector with out_ready high, measure latency, check result and flags.
    task automatic drive_one(input vec_t v, input int idx);
        bit got;
        int n;
        apply_vec(v);
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("vec%0d accepted", idx), {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        check($sformatf("vec%0d latency", idx), n, 32'd2);
        check($sformatf("vec%0d result", idx), result, v.res);
        check($sformatf("vec%0d flags", idx), {29'd0, overflow, underflow, inexact}, {29'd0, v.flg});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_exp[3];
    int          k;
    bit          c_acc;

    initial begin
        //          m          e       fg    r     s     zero  neg   sgn   nan   inf   isg   res            {ovf,udf,ix}
        vecs[0]  = '{23'h7FFFFF, 9'h07F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001};
        vecs[1]  = '{23'h000002, 9'h080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000002, 3'b001};
        vecs[2]  = '{23'h7FFFFF, 9'h0FE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101};
        vecs[3]  = '{23'h123456, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 3'b011};
        vecs[4]  = '{23'h000000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b000};
        vecs[5]  = '{23'h000000, 9'h080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 3'b000};
        vecs[6]  = '{23'h000000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF800000, 3'b000};
        vecs[7]  = '{23'h400000, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hBFC00000, 3'b000};
        vecs[8]  = '{23'h000001, 9'h080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000002, 3'b001};
        vecs[9]  = '{23'h000010, 9'h081, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40800010, 3'b001};
        vecs[10] = '{23'h000005, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 3'b011};
        vecs[11] = '{23'h000000, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF800000, 3'b101};
        vecs[12] = '{23'h000004, 9'h090, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h48000005, 3'b001};
        vecs[13] = '{23'h7FFFFF, 9'h0FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b000};
        vecs[14] = '{23'h000003, 9'h080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40000004, 3'b001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        apply_vec(vecs[0]);
        repeat (2) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'h00000000);
        check("reset flags", {29'd0, overflow, underflow, inexact}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive_one(vecs[i], i);
        end

        // Backpressure: A and B fill the pipe, C must wait.
        out_ready = 1'b0;
        apply_vec(vecs[7]);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp accept A", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        apply_vec(vecs[8]);
        @(negedge clk);
        check("bp accept B", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        apply_vec(vecs[12]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
            check("bp out_valid held", {31'd0, out_valid}, 32'd1);
            check("bp result stable", result, vecs[7].res);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        bp_exp[0] = vecs[7].res;
        bp_exp[1] = vecs[8].res;
        bp_exp[2] = vecs[12].res;
        k = 0;
        c_acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) c_acc = 1'b1;
            if (out_valid) begin
                if (k < 3) check($sformatf("bp drain %0d", k), result, bp_exp[k]);
                k++;
            end
            @(posedge clk);
            #1;
            if (c_acc) in_valid = 1'b0;
        end
        check("bp C accepted", {31'd0, c_acc}, 32'd1);
        check("bp drain count", k, 32'd3);

        // Reset mid-stall discards everything in flight.
        out_ready = 1'b0;
        apply_vec(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        apply_vec(vecs[1]);
        @(posedge clk);
        #1;
        apply_vec(vecs[2]);
        @(negedge clk);
        check("stall before reset", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", {31'd0, out_valid}, 32'd0);
        check("async reset result", result, 32'h00000000);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no stale after reset", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        drive_one(vecs[13], 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
